// File: rtl/bullet_pool_control.sv
// bullet_pool_control: multi-slot projectile pool with edge-triggered fire, cooldown and step ticks
module bullet_pool_control #(
  parameter int NUM_BULLETS = 4,
  parameter int STEP_DIV    = 500000,
  parameter int SPEED       = 1,
  parameter int COOLDOWN    = 2000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_level,
  input  logic                     play,
  input  logic                     fire,
  input  logic [7:0]               playerX,
  input  logic [6:0]               playerY,
  input  logic [NUM_BULLETS-1:0]   hit_vec,
  output logic [8*NUM_BULLETS-1:0] bulletX,
  output logic [7*NUM_BULLETS-1:0] bulletY,
  output logic [NUM_BULLETS-1:0]   active,
  output logic                     move,
  output logic                     shot,
  output logic                     dropped
);
  localparam int CW = $clog2(STEP_DIV);
  localparam int KW = $clog2(COOLDOWN + 1);
  localparam int SW = NUM_BULLETS > 1 ? $clog2(NUM_BULLETS) : 1;
  logic                   fire_q;
  logic [CW-1:0]          step_ctr;
  logic [KW-1:0]          cool;
  logic [SW-1:0]          sel;
  logic [NUM_BULLETS-1:0] step_ok;
  logic                   fire_edge, tick, accept;
  logic [7:0]             park_x;
  logic [6:0]             park_y;
  assign fire_edge = fire & ~fire_q;
  assign tick      = step_ctr == CW'(STEP_DIV - 1);
  assign accept    = play & fire_edge & (cool == '0) & ~&active;
  assign park_x    = playerX + 8'd1;
  assign park_y    = playerY + 7'd1;
  always_comb begin
    sel     = '0;
    step_ok = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) sel = SW'(i);
      step_ok[i] = active[i] & ~hit_vec[i] & (bulletY[7*i +: 7] >= 7'(SPEED));
    end
  end
  always_ff @(posedge clk) begin
    if (reset | load_level) begin
      active   <= '0;
      move     <= 1'b0;
      shot     <= 1'b0;
      dropped  <= 1'b0;
      step_ctr <= '0;
      cool     <= '0;
      fire_q   <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        bulletX[8*i +: 8] <= park_x;
        bulletY[7*i +: 7] <= park_y;
      end
    end else begin
      fire_q  <= fire;
      shot    <= accept;
      dropped <= play & fire_edge & ~accept;
      move    <= play & tick & |step_ok;
      if (play) begin
        step_ctr <= tick ? '0 : step_ctr + 1'b1;
        cool     <= accept ? KW'(COOLDOWN - 1) : (cool != '0 ? cool - 1'b1 : cool);
        for (int i = 0; i < NUM_BULLETS; i++) begin
          if (active[i] && !hit_vec[i]) begin
            if (tick && step_ok[i]) begin
              bulletY[7*i +: 7] <= bulletY[7*i +: 7] - 7'(SPEED);
            end else if (tick) begin
              active[i]         <= 1'b0;
              bulletX[8*i +: 8] <= park_x;
              bulletY[7*i +: 7] <= park_y;
            end
          end else if (accept && sel == SW'(i)) begin
            active[i]         <= 1'b1;
            bulletX[8*i +: 8] <= park_x;
            bulletY[7*i +: 7] <= playerY;
          end else begin
            active[i]         <= 1'b0;
            bulletX[8*i +: 8] <= park_x;
            bulletY[7*i +: 7] <= park_y;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bullet_pool_control.sv
// tb_bullet_pool_control: directed checks of allocation, cooldown, stepping, retire, freeze and clear
module tb_bullet_pool_control;
  logic        clk = 1'b0;
  logic        reset, load_level, play, fire;
  logic [7:0]  playerX;
  logic [6:0]  playerY;
  logic [1:0]  hit_vec;
  logic [15:0] bulletX;
  logic [13:0] bulletY;
  logic [1:0]  active;
  logic        move, shot, dropped;
  int          checks = 0;
  int          errors = 0;
  bullet_pool_control #(.NUM_BULLETS(2), .STEP_DIV(4), .SPEED(1), .COOLDOWN(3)) dut (
    .clk(clk), .reset(reset), .load_level(load_level), .play(play), .fire(fire),
    .playerX(playerX), .playerY(playerY), .hit_vec(hit_vec),
    .bulletX(bulletX), .bulletY(bulletY), .active(active),
    .move(move), .shot(shot), .dropped(dropped)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; load_level = 1'b0; play = 1'b1; fire = 1'b0;
    playerX = 8'd80; playerY = 7'd115; hit_vec = 2'b00;
    cyc(1);
    reset = 1'b0;
    chk("rst_active", int'(active), 0);
    chk("rst_x0", int'(bulletX[7:0]), 81);
    chk("rst_x1", int'(bulletX[15:8]), 81);
    chk("rst_y0", int'(bulletY[6:0]), 116);
    chk("rst_y1", int'(bulletY[13:7]), 116);
    chk("rst_pulses", int'({move, shot, dropped}), 0);
    fire = 1'b1; cyc(1);
    chk("fire1_active", int'(active), 1);
    chk("fire1_x0", int'(bulletX[7:0]), 81);
    chk("fire1_y0", int'(bulletY[6:0]), 115);
    chk("fire1_shot", int'(shot), 1);
    chk("fire1_y1_park", int'(bulletY[13:7]), 116);
    fire = 1'b0; cyc(1);
    fire = 1'b1; cyc(1);
    chk("cool_dropped", int'(dropped), 1);
    chk("cool_active", int'(active), 1);
    chk("cool_shot", int'(shot), 0);
    fire = 1'b0; cyc(1);
    chk("tick1_y0", int'(bulletY[6:0]), 114);
    chk("tick1_move", int'(move), 1);
    fire = 1'b1; cyc(1);
    chk("fire2_active", int'(active), 3);
    chk("fire2_y1", int'(bulletY[13:7]), 115);
    chk("fire2_shot", int'(shot), 1);
    chk("fire2_move", int'(move), 0);
    fire = 1'b0; cyc(2);
    fire = 1'b1; cyc(1);
    chk("full_dropped", int'(dropped), 1);
    chk("full_active", int'(active), 3);
    chk("tick2_y0", int'(bulletY[6:0]), 113);
    chk("tick2_y1", int'(bulletY[13:7]), 114);
    chk("tick2_move", int'(move), 1);
    fire = 1'b0; hit_vec = 2'b01; cyc(1);
    chk("hit0_active", int'(active), 2);
    chk("hit0_y0_park", int'(bulletY[6:0]), 116);
    hit_vec = 2'b00; fire = 1'b1; cyc(1);
    chk("realloc_active", int'(active), 3);
    chk("realloc_y0", int'(bulletY[6:0]), 115);
    chk("realloc_shot", int'(shot), 1);
    fire = 1'b0; play = 1'b0; cyc(4);
    fire = 1'b1; cyc(6);
    chk("pause_y0", int'(bulletY[6:0]), 115);
    chk("pause_y1", int'(bulletY[13:7]), 114);
    chk("pause_active", int'(active), 3);
    chk("pause_pulses", int'({move, shot, dropped}), 0);
    play = 1'b1; cyc(1);
    chk("resume_y1", int'(bulletY[13:7]), 114);
    chk("resume_no_edge", int'({shot, dropped}), 0);
    cyc(1);
    chk("resume_tick_y0", int'(bulletY[6:0]), 114);
    chk("resume_tick_y1", int'(bulletY[13:7]), 113);
    chk("resume_tick_move", int'(move), 1);
    load_level = 1'b1; fire = 1'b0; cyc(1);
    chk("load_active", int'(active), 0);
    chk("load_y0", int'(bulletY[6:0]), 116);
    chk("load_y1", int'(bulletY[13:7]), 116);
    chk("load_x0", int'(bulletX[7:0]), 81);
    chk("load_move", int'(move), 0);
    load_level = 1'b0; playerY = 7'd1; fire = 1'b1; cyc(1);
    chk("low_active", int'(active), 1);
    chk("low_y0", int'(bulletY[6:0]), 1);
    chk("low_y1_park", int'(bulletY[13:7]), 2);
    chk("low_shot", int'(shot), 1);
    fire = 1'b0; cyc(3);
    chk("low_tick_y0", int'(bulletY[6:0]), 0);
    chk("low_tick_move", int'(move), 1);
    cyc(2);
    chk("zero_hold_y0", int'(bulletY[6:0]), 0);
    chk("zero_hold_active", int'(active), 1);
    cyc(1);
    fire = 1'b1; cyc(1);
    chk("top_retire_active", int'(active), 2);
    chk("top_retire_y0", int'(bulletY[6:0]), 2);
    chk("spawn_tick_y1", int'(bulletY[13:7]), 1);
    chk("top_retire_move", int'(move), 0);
    chk("spawn_tick_shot", int'(shot), 1);
    fire = 1'b0; cyc(2);
    fire = 1'b1; cyc(1);
    chk("refill_active", int'(active), 3);
    chk("refill_y0", int'(bulletY[6:0]), 1);
    fire = 1'b0; hit_vec = 2'b11; cyc(1);
    chk("dual_hit_active", int'(active), 0);
    chk("dual_hit_move", int'(move), 0);
    chk("dual_hit_y0", int'(bulletY[6:0]), 2);
    chk("dual_hit_y1", int'(bulletY[13:7]), 2);
    playerX = 8'd100; cyc(1);
    chk("idle_hit_active", int'(active), 0);
    chk("track_x0", int'(bulletX[7:0]), 101);
    chk("track_x1", int'(bulletX[15:8]), 101);
    hit_vec = 2'b00; cyc(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
